// File: rtl/xadc_drp_arbiter.sv
// XADC DRP arbiter: round-robin between the aux-channel scan and the host.
// One DRP transaction outstanding at a time, with a DRDY timeout.
module xadc_drp_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        EOS,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_err,
  output logic [11:0] MEASURED_AUX0,
  output logic [11:0] MEASURED_AUX1,
  output logic [11:0] MEASURED_AUX2,
  output logic [11:0] MEASURED_AUX3,
  output logic        scan_done,
  output logic        scan_overrun,
  output logic        scan_err
);

  localparam int CW =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    CH_LAST = 2'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN_ISSUE,
    SCAN_WAIT,
    HOST_ISSUE,
    HOST_WAIT
  } state_t;

  state_t        state;
  logic [1:0]    ch;
  logic [1:0]    ch_inc;
  logic [CW-1:0] cnt;
  logic          scan_pending;
  logic          last_host;
  logic [11:0]   aux [4];

  logic scan_req;
  logic host_live;
  logic in_scan;
  logic grant_scan;
  logic grant_host;
  logic timed_out;

  // EOS counts as a scan request in the same cycle so a tie
  // with host_req from reset is resolved in favour of the scan.
  assign scan_req   = scan_pending | EOS;
  assign host_live  = host_req & ~host_ack;
  assign in_scan    = (state == SCAN_ISSUE) || (state == SCAN_WAIT);
  assign grant_scan = (state == IDLE) && scan_req &&
                      (!host_live || last_host);
  assign grant_host = (state == IDLE) && host_live &&
                      (!scan_req || !last_host);
  assign timed_out  = (cnt >= TO_LAST);
  assign ch_inc     = ch + 2'd1;

  assign MEASURED_AUX0 = (NUM_CH > 0) ? aux[0] : 12'd0;
  assign MEASURED_AUX1 = (NUM_CH > 1) ? aux[1] : 12'd0;
  assign MEASURED_AUX2 = (NUM_CH > 2) ? aux[2] : 12'd0;
  assign MEASURED_AUX3 = (NUM_CH > 3) ? aux[3] : 12'd0;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state        <= IDLE;
      DEN          <= 1'b0;
      DWE          <= 1'b0;
      DADDR        <= 7'd0;
      DI           <= 16'd0;
      host_ack     <= 1'b0;
      host_err     <= 1'b0;
      host_rdata   <= 16'd0;
      scan_done    <= 1'b0;
      scan_overrun <= 1'b0;
      scan_err     <= 1'b0;
      scan_pending <= 1'b0;
      ch           <= 2'd0;
      cnt          <= '0;
      last_host    <= 1'b1;
      for (int i = 0; i < 4; i++) aux[i] <= 12'd0;
    end else begin
      DEN          <= 1'b0;
      host_ack     <= 1'b0;
      host_err     <= 1'b0;
      scan_done    <= 1'b0;
      scan_err     <= 1'b0;
      scan_overrun <= EOS & (scan_pending | in_scan);

      // A grant consumes the pending request; an EOS on top of an
      // already-pending one is coalesced and kept for later.
      if (grant_scan)
        scan_pending <= EOS & scan_pending;
      else if (EOS)
        scan_pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if (grant_scan) begin
            state     <= SCAN_ISSUE;
            ch        <= 2'd0;
            DEN       <= 1'b1;
            DWE       <= 1'b0;
            DADDR     <= 7'h10;
            cnt       <= '0;
            last_host <= 1'b0;
          end else if (grant_host) begin
            state     <= HOST_ISSUE;
            DEN       <= 1'b1;
            DWE       <= host_we;
            DADDR     <= host_addr;
            DI        <= host_wdata;
            cnt       <= '0;
            last_host <= 1'b1;
          end
        end
        SCAN_ISSUE: begin
          state <= SCAN_WAIT;
          cnt   <= cnt + CW'(1);
        end
        SCAN_WAIT: begin
          if (DRDY || timed_out) begin
            if (DRDY)
              aux[ch] <= DO[15:4];
            else
              scan_err <= 1'b1;
            if (ch != CH_LAST) begin
              state <= SCAN_ISSUE;
              ch    <= ch_inc;
              DEN   <= 1'b1;
              DWE   <= 1'b0;
              DADDR <= 7'h10 + {5'd0, ch_inc};
              cnt   <= '0;
            end else begin
              state     <= IDLE;
              ch        <= 2'd0;
              scan_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOST_ISSUE: begin
          state <= HOST_WAIT;
          cnt   <= cnt + CW'(1);
        end
        HOST_WAIT: begin
          if (DRDY) begin
            state    <= IDLE;
            host_ack <= 1'b1;
            if (!DWE) host_rdata <= DO;
          end else if (timed_out) begin
            state    <= IDLE;
            host_ack <= 1'b1;
            host_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
